// File: rtl/alu181_pkg.sv
// Shared types and function-select codes for the slice-serial 74181-style ALU.
package alu181_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [3:0] FN_ADD = 4'b1001;  // m = 0
  localparam logic [3:0] FN_SUB = 4'b0110;  // m = 0, A - B - 1 + c0
  localparam logic [3:0] FN_XOR = 4'b0110;  // m = 1

endpackage

// File: rtl/alu181_slice.sv
// Combinational 4-bit 74181-equivalent slice with active-high data.
module alu181_slice
  import alu181_pkg::*;
(
  input  logic [3:0] a4,
  input  logic [3:0] b4,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       cin,
  output logic [3:0] f4,
  output logic       cout,
  output logic       g4,
  output logic       p4
);

  logic [3:0] e;
  logic [3:0] d;
  logic [4:0] c;
  logic [4:0] gc;

  assign e = ~((a4 & b4 & {4{s[3]}}) | (a4 & ~b4 & {4{s[2]}}));
  assign d = ~(a4 | (~b4 & {4{s[1]}}) | (b4 & {4{s[0]}}));

  always_comb begin
    f4    = '0;
    c     = '0;
    gc    = '0;
    c[0]  = cin;
    for (int unsigned i = 0; i < 4; i++) begin
      f4[i]     = e[i] ^ d[i] ^ (c[i] | m);
      c[i+1]    = ~d[i] & (c[i] | ~e[i]);
      gc[i+1]   = ~d[i] & (gc[i] | ~e[i]);
    end
  end

  assign cout = c[4];
  assign g4   = gc[4];
  assign p4   = &e;

endmodule

// File: rtl/alu181_serial.sv
// Slice-serial WIDTH-bit 74181-style ALU: one 4-bit slice per clock, LSB first,
// with valid/ready handshakes, accumulator operand and full-word flags.
module alu181_serial
  import alu181_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             cn_b,
  input  logic             use_acc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             cn4_b,
  output logic             x,
  output logic             y,
  output logic             aeb
);

  localparam int unsigned NS = WIDTH / 4;
  localparam int unsigned IW = (NS > 1) ? $clog2(NS) : 1;

  state_t           state, next_state;
  logic [WIDTH-1:0] a_sh, b_sh, acc, f_r;
  logic [3:0]       s_r;
  logic             m_r, carry, g_acc, p_acc;
  logic [IW-1:0]    idx;
  logic             last;

  logic [3:0]       f4;
  logic             cout, g4, p4;

  alu181_slice u_slice (
    .a4   (a_sh[3:0]),
    .b4   (b_sh[3:0]),
    .s    (s_r),
    .m    (m_r),
    .cin  (carry),
    .f4   (f4),
    .cout (cout),
    .g4   (g4),
    .p4   (p4)
  );

  assign last = (idx == IW'(NS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid && !flush) next_state = RUN;
      RUN:     if (flush) next_state = IDLE;
               else if (last) next_state = DONE;
      DONE:    if (flush || out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      f_r   <= '0;
      s_r   <= '0;
      m_r   <= 1'b0;
      carry <= 1'b0;
      g_acc <= 1'b0;
      p_acc <= 1'b0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid && !flush) begin
          a_sh  <= a;
          b_sh  <= use_acc ? acc : b;
          s_r   <= s;
          m_r   <= m;
          carry <= ~cn_b;
          g_acc <= 1'b0;
          p_acc <= 1'b1;
          idx   <= '0;
        end
        RUN: if (!flush) begin
          f_r[4*idx +: 4] <= f4;
          a_sh  <= a_sh >> 4;
          b_sh  <= b_sh >> 4;
          carry <= cout;
          // The cin=0 chain never exceeds the real chain, so when it is set the
          // real carry is set too and cout is exactly its slice carry-out.
          g_acc <= g_acc ? cout : g4;
          p_acc <= p_acc & p4;
          idx   <= idx + 1'b1;
        end
        DONE: if (out_ready && !flush) acc <= f_r;
        default: ;
      endcase
    end
  end

  assign f     = f_r;
  assign cn4_b = ~carry;
  assign x     = ~p_acc;
  assign y     = ~g_acc;
  assign aeb   = &f_r;

endmodule

// File: tb/tb_alu181_serial.sv
// Directed self-checking bench for alu181_serial at WIDTH = 16.
module tb_alu181_serial;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, m, cn_b, use_acc, flush;
  logic        out_valid, out_ready, cn4_b, x, y, aeb;
  logic [15:0] a, b, f;
  logic [3:0]  s;
  int          errors = 0;
  int          checks = 0;

  alu181_serial #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .s         (s),
    .m         (m),
    .cn_b      (cn_b),
    .use_acc   (use_acc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f),
    .cn4_b     (cn4_b),
    .x         (x),
    .y         (y),
    .aeb       (aeb)
  );

  always #5 clk = ~clk;

  // Issue one request, scramble the inputs after accept, and wait (bounded) for out_valid.
  // lat counts clock edges including the accepting edge.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic [3:0] ts,
                        input logic tm, input logic tcn, input logic tuse, output int lat);
    @(negedge clk);
    a = ta; b = tb; s = ts; m = tm; cn_b = tcn; use_acc = tuse; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~ta; b = ~tb; s = ~ts; m = ~tm; cn_b = ~tcn; use_acc = ~tuse;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_op();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, f, cn4_b, x, y, aeb} !== {1'b1, 1'b0, 16'h0000, 4'b1110}) begin
      errors++;
      $display("FAIL reset: got rdy=%b vld=%b f=%h c=%b x=%b y=%b aeb=%b want 1 0 0000 1 1 1 0",
               in_ready, out_valid, f, cn4_b, x, y, aeb);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int lat;
    run_op(16'h1234, 16'h4321, 4'b1001, 1'b0, 1'b1, 1'b0, lat);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL add_latency: got %0d want 5", lat); end
    checks++;
    if ({f, cn4_b, x, y, aeb} !== {16'h5555, 4'b1110}) begin
      errors++;
      $display("FAIL add: got f=%h c=%b x=%b y=%b aeb=%b want 5555 1 1 1 0", f, cn4_b, x, y, aeb);
    end
    release_op();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL add_release: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_carry_wrap();
    int lat;
    run_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 1'b0, lat);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL wrap_latency: got %0d want 5", lat); end
    checks++;
    if ({f, cn4_b, x, y, aeb} !== {16'h0000, 4'b0100}) begin
      errors++;
      $display("FAIL wrap: got f=%h c=%b x=%b y=%b aeb=%b want 0000 0 1 0 0", f, cn4_b, x, y, aeb);
    end
    release_op();
  endtask

  task automatic test_equality();
    int lat;
    run_op(16'h00A5, 16'h00A5, 4'b0110, 1'b0, 1'b1, 1'b0, lat);
    checks++;
    if ({f, cn4_b, x, y, aeb} !== {16'hFFFF, 4'b1011}) begin
      errors++;
      $display("FAIL equal: got f=%h c=%b x=%b y=%b aeb=%b want ffff 1 0 1 1", f, cn4_b, x, y, aeb);
    end
    release_op();
  endtask

  task automatic test_acc_backpressure();
    int lat;
    int bad;
    run_op(16'hF0F0, 16'h0FF0, 4'b0110, 1'b1, 1'b1, 1'b0, lat);
    checks++;
    if ({f, cn4_b, x, y, aeb} !== {16'hFF00, 4'b0100}) begin
      errors++;
      $display("FAIL xor: got f=%h c=%b x=%b y=%b aeb=%b want ff00 0 1 0 0", f, cn4_b, x, y, aeb);
    end
    // Hold with a competing request present; it must not be taken.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if ({f, out_valid, in_ready} !== {16'hFF00, 2'b10}) bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL hold: got %0d unstable cycles want 0", bad); end
    release_op();
    run_op(16'hFF00, 16'h1234, 4'b0110, 1'b1, 1'b1, 1'b1, lat);
    checks++;
    if ({f, cn4_b, x, y, aeb} !== {16'h0000, 4'b1010}) begin
      errors++;
      $display("FAIL acc_xor: got f=%h c=%b x=%b y=%b aeb=%b want 0000 1 0 1 0", f, cn4_b, x, y, aeb);
    end
    release_op();
  endtask

  task automatic test_flush_abort();
    int lat;
    int seen;
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; s = 4'b1001; m = 1'b0; cn_b = 1'b1; use_acc = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (out_valid !== 1'b0) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL flush_quiet: got %0d valid cycles want 0", seen); end
    run_op(16'h0001, 16'h0001, 4'b1001, 1'b0, 1'b1, 1'b0, lat);
    checks++;
    if ({lat[7:0], f, cn4_b, x, y, aeb} !== {8'd5, 16'h0002, 4'b1110}) begin
      errors++;
      $display("FAIL flush_next: got lat=%0d f=%h c=%b x=%b y=%b aeb=%b want 5 0002 1 1 1 0",
               lat, f, cn4_b, x, y, aeb);
    end
    release_op();
  endtask

  task automatic test_reset_abort();
    int lat;
    int seen;
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; s = 4'b1001; m = 1'b0; cn_b = 1'b1; use_acc = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, f, cn4_b, x, y, aeb} !== {1'b1, 1'b0, 16'h0000, 4'b1110}) begin
      errors++;
      $display("FAIL reset_abort: got rdy=%b vld=%b f=%h c=%b x=%b y=%b aeb=%b want 1 0 0000 1 1 1 0",
               in_ready, out_valid, f, cn4_b, x, y, aeb);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (out_valid !== 1'b0) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL reset_quiet: got %0d valid cycles want 0", seen); end
    // Accumulator was cleared by reset, so this is 0x0007 + 0.
    run_op(16'h0007, 16'hAAAA, 4'b1001, 1'b0, 1'b1, 1'b1, lat);
    checks++;
    if ({f, cn4_b, x, y, aeb} !== {16'h0007, 4'b1010}) begin
      errors++;
      $display("FAIL acc_after_reset: got f=%h c=%b x=%b y=%b aeb=%b want 0007 1 0 1 0", f, cn4_b, x, y, aeb);
    end
    release_op();
    run_op(16'h0001, 16'h0001, 4'b1001, 1'b0, 1'b1, 1'b0, lat);
    checks++;
    if ({lat[7:0], f, cn4_b} !== {8'd5, 16'h0002, 1'b1}) begin
      errors++;
      $display("FAIL reset_next: got lat=%0d f=%h c=%b want 5 0002 1", lat, f, cn4_b);
    end
    release_op();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    a = '0; b = '0; s = '0; m = 1'b0; cn_b = 1'b1; use_acc = 1'b0;
    test_reset();
    test_add();
    test_carry_wrap();
    test_equality();
    test_acc_backpressure();
    test_flush_abort();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
